dense_mac_sched: RTL and testbench
==================================

# dense_mac_sched

Sequencer for the Dense layer's pipelined 16x16 signed multiplier. It walks the input-vector and weight memories, feeds one operand pair per cycle into the multiplier with its clock enable, and tracks products through the multiplier latency. It accumulates each neuron's dot product plus bias and hands out one 32-bit result per neuron over a valid/ready port. It sits between the layer's BRAMs and the output stream of the Dense operator.

## Interface
Parameters:
- IN_LEN, 16, input vector length (MACs per neuron), >= 1
- OUT_LEN, 10, number of neurons per run, >= 1
- MUL_LAT, 3, cycles from operands presented with mul_ce=1 to matching mul_dout
- AW, 16, address width of all memory ports

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a run; sampled only in IDLE
- busy  out  1  high from first issue cycle until done
- done  out  1  one-cycle pulse after last result accepted
- x_addr  out  AW  input-vector read address (memory read latency 1)
- x_data  in  16  signed input element
- w_addr  out  AW  weight read address (latency 1)
- w_data  in  16  signed weight
- b_addr  out  AW  bias read address (latency 1)
- b_data  in  32  signed bias
- mul_din0  out  16  multiplier operand A (= x_data, registered path)
- mul_din1  out  16  multiplier operand B (= w_data)
- mul_ce  out  1  multiplier clock enable
- mul_dout  in  32  signed product from multiplier
- y_valid  out  1  result valid
- y_ready  in  1  downstream accepts result
- y_data  out  32  signed neuron result
- y_idx  out  AW  neuron index of y_data

## Operation
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE: all outputs 0. start=1 -> ISSUE with n=0, k=0.
- ISSUE: per cycle drive x_addr=k, w_addr=n*IN_LEN+k, b_addr=n; k increments; after k=IN_LEN-1 -> DRAIN.
- Operands: mul_din0/mul_din1 forward x_data/w_data one cycle after their address; a valid-tag shift register (length 1+MUL_LAT) tracks live products.
- Accumulator: bias captured one cycle after first address of the neuron; each tagged mul_dout is added; first product adds onto bias. Arithmetic 32-bit two's complement, wraps modulo 2^32, no saturation.
- DRAIN: wait until tag register empty and last add done -> OUT, y_valid=1, y_data=acc, y_idx=n.
- OUT: on y_valid&&y_ready: if n=OUT_LEN-1 -> IDLE, done pulse next cycle; else n++, k=0 -> ISSUE.
- Neurons do not overlap; multiplier pipeline is empty at every OUT.
- mul_ce=1 in ISSUE and DRAIN; 0 in IDLE and OUT.
- start while busy: ignored. y_ready while y_valid=0: ignored.
- Reset mid-run: immediate return to IDLE, accumulator and tags cleared, no done, no partial result.

## Timing
- Reset values: busy, done, y_valid, mul_ce = 0; all addresses, mul_din0/1, y_data, y_idx = 0.
- start high in cycle c (IDLE) -> busy=1 and first x_addr in cycle c+1.
- First address of a neuron in cycle t -> y_valid in cycle t+IN_LEN+MUL_LAT+1 (defaults: t+20).
- y_data, y_idx stable while y_valid=1 and y_ready=0; addresses hold last values.
- Handshake in cycle h -> next neuron's first address in h+1; after last neuron, done=1 and busy=0 in h+1.
- Run length with y_ready tied high: OUT_LEN*(IN_LEN+MUL_LAT+2) cycles of busy.

## Test plan
- All x=1, w=1, bias=0, defaults, y_ready=1 -> ten results y_data=16, y_idx 0..9, y_valid at t+20 each, single done pulse.
- x[k]=k, w=row n all 2, bias[n]=-n -> y_data=240-n for each n; w_addr sequence n*16+k verified.
- x=w=-32768 all, bias=0 -> each product 2^30, sum wraps to y_data=0; with bias=5 -> 5.
- Hold y_ready low 7 cycles at neuron 3 -> y_data/y_idx stable, mul_ce=0, no new addresses, resume at h+1.
- Assert reset during neuron 2 ISSUE -> all outputs 0 same cycle; new start gives correct results from neuron 0.
- start pulsed while busy, IN_LEN=1 build -> pulse ignored; y_valid 5 cycles after each address (MUL_LAT=3).

Source files
------------

// File: rtl/dense_mac_sched.sv
// Dense layer MAC sequencer: walks x/w/bias memories, feeds an external pipelined
// multiplier, accumulates bias + dot product per neuron and streams results out.
module dense_mac_sched #(
  parameter int IN_LEN  = 16,
  parameter int OUT_LEN = 10,
  parameter int MUL_LAT = 3,
  parameter int AW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] x_addr,
  input  logic [15:0]   x_data,
  output logic [AW-1:0] w_addr,
  input  logic [15:0]   w_data,
  output logic [AW-1:0] b_addr,
  input  logic [31:0]   b_data,
  output logic [15:0]   mul_din0,
  output logic [15:0]   mul_din1,
  output logic          mul_ce,
  input  logic [31:0]   mul_dout,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [31:0]   y_data,
  output logic [AW-1:0] y_idx
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   x_addr_reg, w_addr_reg, b_addr_reg;
  logic [MUL_LAT:0] tag_reg, tag_next;
  logic            bias_cap_reg;
  logic [31:0]     acc_reg;
  logic            done_reg;

  logic last_k, last_n, tags_drained;

  // x_addr doubles as the MAC index k and b_addr as the neuron index n
  assign last_k       = (x_addr_reg == AW'(IN_LEN - 1));
  assign last_n       = (b_addr_reg == AW'(OUT_LEN - 1));
  // Only the final stage may still hold a product; it is added on this same edge
  assign tags_drained = (tag_reg[MUL_LAT-1:0] == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = ISSUE;
      ISSUE: if (last_k) state_next = DRAIN;
      DRAIN: if (tags_drained && !bias_cap_reg) state_next = OUT;
      OUT:   if (y_ready) state_next = last_n ? IDLE : ISSUE;
      default: state_next = IDLE;
    endcase
  end

  // Valid-tag chain: stage 0 marks operands at the multiplier input,
  // stage MUL_LAT marks the matching product on mul_dout.
  assign tag_next[0] = (state_reg == ISSUE);
  generate
    for (genvar gi = 1; gi <= MUL_LAT; gi++) begin : g_tag
      assign tag_next[gi] = tag_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       tag_reg <= '0;
    else if (mul_ce) tag_reg <= tag_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_addr_reg   <= '0;
      w_addr_reg   <= '0;
      b_addr_reg   <= '0;
      bias_cap_reg <= 1'b0;
      acc_reg      <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg     <= (state_reg == OUT) && y_ready && last_n;
      bias_cap_reg <= (state_reg == ISSUE) && (x_addr_reg == '0);
      acc_reg      <= (bias_cap_reg ? b_data : acc_reg) +
                      (tag_reg[MUL_LAT] ? mul_dout : 32'd0);
      case (state_reg)
        ISSUE: begin
          if (!last_k) begin
            x_addr_reg <= x_addr_reg + 1'b1;
            w_addr_reg <= w_addr_reg + 1'b1;
          end
        end
        OUT: begin
          if (y_ready) begin
            if (last_n) begin
              x_addr_reg <= '0;
              w_addr_reg <= '0;
              b_addr_reg <= '0;
            end else begin
              // w_addr sits on n*IN_LEN+IN_LEN-1, so +1 is the next row base
              x_addr_reg <= '0;
              w_addr_reg <= w_addr_reg + 1'b1;
              b_addr_reg <= b_addr_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign mul_ce   = (state_reg == ISSUE) || (state_reg == DRAIN);
  assign x_addr   = x_addr_reg;
  assign w_addr   = w_addr_reg;
  assign b_addr   = b_addr_reg;
  assign mul_din0 = tag_reg[0] ? x_data : 16'd0;
  assign mul_din1 = tag_reg[0] ? w_data : 16'd0;
  assign y_valid  = (state_reg == OUT);
  assign y_data   = y_valid ? acc_reg : 32'd0;
  assign y_idx    = y_valid ? b_addr_reg : '0;

endmodule

// File: tb/tb_dense_mac_sched.sv
// Directed bench for dense_mac_sched: default build plus an IN_LEN=1 build,
// with behavioural BRAMs and a 3-stage clock-enabled multiplier.
module tb_dense_mac_sched;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, y_ready;
  logic busy, done, mul_ce, y_valid;
  logic [AW-1:0] x_addr, w_addr, b_addr, y_idx;
  logic [15:0] x_data, w_data, mul_din0, mul_din1;
  logic [31:0] b_data, mul_dout, y_data;

  logic start1, y_ready1;
  logic busy1, done1, mul_ce1, y_valid1;
  logic [AW-1:0] x_addr1, w_addr1, b_addr1, y_idx1;
  logic [15:0] x_data1, w_data1, mul_din01, mul_din11;
  logic [31:0] b_data1, mul_dout1, y_data1;

  dense_mac_sched u0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_ce(mul_ce), .mul_dout(mul_dout), .y_valid(y_valid), .y_ready(y_ready),
    .y_data(y_data), .y_idx(y_idx)
  );

  dense_mac_sched #(.IN_LEN(1), .OUT_LEN(3)) u1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .x_addr(x_addr1), .x_data(x_data1), .w_addr(w_addr1), .w_data(w_data1),
    .b_addr(b_addr1), .b_data(b_data1), .mul_din0(mul_din01), .mul_din1(mul_din11),
    .mul_ce(mul_ce1), .mul_dout(mul_dout1), .y_valid(y_valid1), .y_ready(y_ready1),
    .y_data(y_data1), .y_idx(y_idx1)
  );

  // Memories with one-cycle registered read
  logic [15:0] x_mem [16];
  logic [15:0] w_mem [256];
  logic [31:0] b_mem [16];
  logic [15:0] x1_mem [4];
  logic [15:0] w1_mem [4];
  logic [31:0] b1_mem [4];

  always @(posedge clk) begin
    x_data  <= x_mem[x_addr[3:0]];
    w_data  <= w_mem[w_addr[7:0]];
    b_data  <= b_mem[b_addr[3:0]];
    x_data1 <= x1_mem[x_addr1[1:0]];
    w_data1 <= w1_mem[w_addr1[1:0]];
    b_data1 <= b1_mem[b_addr1[1:0]];
  end

  // Pipelined multipliers, latency 3, advancing only when enabled
  logic signed [31:0] p0 [3];
  logic signed [31:0] p1 [3];
  always @(posedge clk) begin
    if (mul_ce) begin
      p0[0] <= $signed(mul_din0) * $signed(mul_din1);
      p0[1] <= p0[0];
      p0[2] <= p0[1];
    end
    if (mul_ce1) begin
      p1[0] <= $signed(mul_din01) * $signed(mul_din11);
      p1[1] <= p1[0];
      p1[2] <= p1[1];
    end
  end
  assign mul_dout  = p0[2];
  assign mul_dout1 = p1[2];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_y [10];
  logic [31:0] exp1 [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run of u0; optional y_ready stall of 7 cycles at neuron hold_n
  task automatic do_run(input int hold_n, input bit chk_w);
    int cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      chk("busy", busy, 1);
      chk("first_x", x_addr, 0);
      chk("first_w", w_addr, 32'(n * 16));
      chk("b_addr", b_addr, 32'(n));
      chk("yv_low", y_valid, 0);
      if (n == hold_n) y_ready = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (chk_w) begin
          chk("w_seq", w_addr, 32'(n * 16 + k));
          chk("x_seq", x_addr, 32'(k));
        end
        tick();
      end
      cnt = 16;
      while (!y_valid && cnt < 40) begin
        tick();
        cnt++;
      end
      chk("latency", 32'(cnt), 20);
      chk("y_data", y_data, exp_y[n]);
      chk("y_idx", y_idx, 32'(n));
      chk("done_low", done, 0);
      if (n == hold_n) begin
        for (int i = 0; i < 7; i++) begin
          chk("hold_valid", y_valid, 1);
          chk("hold_data", y_data, exp_y[n]);
          chk("hold_idx", y_idx, 32'(n));
          chk("hold_ce", mul_ce, 0);
          chk("hold_x", x_addr, 15);
          chk("hold_w", w_addr, 32'(n * 16 + 15));
          if (i == 6) y_ready = 1'b1;
          tick();
        end
      end else begin
        tick();
      end
    end
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    tick();
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b0; y_ready = 1'b1;
    start1 = 1'b0; y_ready1 = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_yvalid", y_valid, 0);
    chk("rst_ce", mul_ce, 0);
    chk("rst_xaddr", x_addr, 0);
    chk("rst_din0", mul_din0, 0);
    chk("rst_ydata", y_data, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_yidx", y_idx, 0);

    // All ones, bias 0, stall at neuron 3
    for (int k = 0; k < 16; k++) x_mem[k] = 16'd1;
    for (int i = 0; i < 256; i++) w_mem[i] = 16'd1;
    for (int n = 0; n < 16; n++) b_mem[n] = 32'd0;
    for (int n = 0; n < 10; n++) exp_y[n] = 32'd16;
    do_run(3, 1'b0);

    // x[k]=k, w=2, bias=-n -> 240-n, with address sequence checks
    for (int k = 0; k < 16; k++) x_mem[k] = 16'(k);
    for (int i = 0; i < 256; i++) w_mem[i] = 16'd2;
    for (int n = 0; n < 16; n++) b_mem[n] = 32'(-n);
    for (int n = 0; n < 10; n++) exp_y[n] = 32'(240 - n);
    do_run(-1, 1'b1);

    // Most-negative operands: 16 * 2^30 wraps to 0
    for (int k = 0; k < 16; k++) x_mem[k] = 16'h8000;
    for (int i = 0; i < 256; i++) w_mem[i] = 16'h8000;
    for (int n = 0; n < 16; n++) b_mem[n] = 32'd0;
    for (int n = 0; n < 10; n++) exp_y[n] = 32'd0;
    do_run(-1, 1'b0);
    for (int n = 0; n < 16; n++) b_mem[n] = 32'd5;
    for (int n = 0; n < 10; n++) exp_y[n] = 32'd5;
    do_run(-1, 1'b0);

    // Reset during neuron 2, k=5, then a clean run
    for (int k = 0; k < 16; k++) x_mem[k] = 16'd1;
    for (int i = 0; i < 256; i++) w_mem[i] = 16'd1;
    for (int n = 0; n < 16; n++) b_mem[n] = 32'd0;
    for (int n = 0; n < 10; n++) exp_y[n] = 32'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (47) tick();
    chk("pre_rst_x", x_addr, 5);
    chk("pre_rst_b", b_addr, 2);
    chk("pre_rst_din0", mul_din0, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ce", mul_ce, 0);
    chk("mid_rst_x", x_addr, 0);
    chk("mid_rst_w", w_addr, 0);
    chk("mid_rst_b", b_addr, 0);
    chk("mid_rst_din0", mul_din0, 0);
    chk("mid_rst_din1", mul_din1, 0);
    chk("mid_rst_valid", y_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    do_run(-1, 1'b0);

    // IN_LEN=1 build: latency 5 per neuron, stray start pulse while busy
    x1_mem[0] = 16'd3;
    w1_mem[0] = 16'd7;  w1_mem[1] = 16'hFFFE; w1_mem[2] = 16'd100;
    b1_mem[0] = 32'd1;  b1_mem[1] = 32'd2;    b1_mem[2] = 32'hFFFF_FED4;
    exp1[0] = 32'd22;   exp1[1] = 32'hFFFF_FFFC; exp1[2] = 32'd0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk("u1_busy", busy1, 1);
      chk("u1_x", x_addr1, 0);
      chk("u1_w", w_addr1, 32'(n));
      chk("u1_b", b_addr1, 32'(n));
      cnt = 0;
      while (!y_valid1 && cnt < 20) begin
        start1 = (n == 0 && cnt == 1);
        tick();
        cnt++;
      end
      start1 = 1'b0;
      chk("u1_latency", 32'(cnt), 5);
      chk("u1_y_data", y_data1, exp1[n]);
      chk("u1_y_idx", y_idx1, 32'(n));
      tick();
    end
    chk("u1_done", done1, 1);
    chk("u1_busy_end", busy1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("u1_stay_idle", busy1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
